// File: rtl/vu_pkg.sv
// Shared constants, FSM encoding and sample-magnitude helper for the VU level processor.
package vu_pkg;

    localparam logic [7:0] ZERO_CODE   = 8'd128;
    localparam logic [7:0] MAG_FULL    = 8'd128;
    localparam logic [7:0] CLIP_THRESH = 8'd127;

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] SCALE = 2'd1;
    localparam logic [1:0] APPLY = 2'd2;

    function automatic logic [7:0] sample_mag(input logic [7:0] s);
        return (s >= ZERO_CODE) ? (s - ZERO_CODE) : (ZERO_CODE - s);
    endfunction

endpackage

// File: rtl/vu_scaler.sv
// Registered magnitude-to-rows scaler: target = (win * BAR_MAX) / MAG_FULL.
module vu_scaler
    import vu_pkg::*;
#(
    parameter int C_SIZE  = 9,
    parameter int BAR_MAX = 480
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [7:0]      win,
    output logic [C_SIZE:0] target
);

    localparam int SHIFT = $clog2(MAG_FULL);

    logic [17:0] product;

    assign product = 18'(win) * 18'(BAR_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            target <= '0;
        else if (load)
            target <= (C_SIZE+1)'(product >> SHIFT);
    end

endmodule

// File: rtl/vu_level_proc.sv
// Per-frame VU level processor: window max, scale, attack/release, peak hold, clip.
// Define VU_PEAK_HOLD_EN to enable the held peak marker; otherwise peak follows level.
module vu_level_proc
    import vu_pkg::*;
#(
    parameter int C_SIZE      = 9,
    parameter int BAR_MAX     = 480,
    parameter int DECAY_STEP  = 4,
    parameter int HOLD_FRAMES = 30
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            sample_valid,
    input  logic [7:0]      sample,
    input  logic            error,
    input  logic            frame_tick,
    output logic [C_SIZE:0] level,
    output logic [C_SIZE:0] peak,
    output logic            clip,
    output logic            upd
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [C_SIZE:0] DECAY     = (C_SIZE+1)'(DECAY_STEP);
    localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLD_FRAMES);

    logic [1:0]      state;
    logic [7:0]      mag, mag_max, win;
    logic            accept, tick_go, apply_en;
    logic [C_SIZE:0] target, level_dec, level_nxt;
    logic [HW-1:0]   clip_cnt;

    assign mag      = sample_mag(sample);
    assign accept   = sample_valid & ~error & enable;
    assign tick_go  = frame_tick & enable & (state == ACCUM);
    assign apply_en = enable & (state == APPLY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ACCUM;
            mag_max <= '0;
            win     <= '0;
        end else if (enable) begin
            case (state)
                ACCUM:   if (frame_tick) state <= SCALE;
                SCALE:   state <= APPLY;
                default: state <= ACCUM;
            endcase
            // A sample arriving with the tick opens the new window.
            if (tick_go) begin
                win     <= mag_max;
                mag_max <= accept ? mag : '0;
            end else if (accept && (mag > mag_max)) begin
                mag_max <= mag;
            end
        end
    end

    vu_scaler #(
        .C_SIZE  (C_SIZE),
        .BAR_MAX (BAR_MAX)
    ) u_scaler (
        .clock  (clock),
        .reset  (reset),
        .load   (enable & (state == SCALE)),
        .win    (win),
        .target (target)
    );

    always_comb begin
        level_dec = (level >= DECAY) ? (level - DECAY) : '0;
        level_nxt = (target >= level) ? target :
                    ((target > level_dec) ? target : level_dec);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level    <= '0;
            clip     <= 1'b0;
            clip_cnt <= '0;
            upd      <= 1'b0;
        end else begin
            upd <= apply_en;
            if (apply_en) begin
                level <= level_nxt;
                if (win >= CLIP_THRESH) begin
                    clip     <= 1'b1;
                    clip_cnt <= HOLD_INIT;
                end else if (clip_cnt != '0) begin
                    clip_cnt <= clip_cnt - 1'b1;
                    if (clip_cnt == HW'(1))
                        clip <= 1'b0;
                end
            end
        end
    end

`ifdef VU_PEAK_HOLD_EN
    logic [HW-1:0]   hold;
    logic [C_SIZE:0] peak_dec;

    assign peak_dec = (peak >= DECAY) ? (peak - DECAY) : '0;

    // Peak tracks the freshly computed level, not the registered one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            peak <= '0;
            hold <= '0;
        end else if (apply_en) begin
            if (level_nxt >= peak) begin
                peak <= level_nxt;
                hold <= HOLD_INIT;
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
            end else begin
                peak <= (level_nxt > peak_dec) ? level_nxt : peak_dec;
            end
        end
    end
`else
    assign peak = level;
`endif

endmodule
